conv_8b_32b: RTL and testbench

Byte-to-word assembler that sits directly downstream of the 32-bit-to-8-bit converter in the serial datapath. It samples the 8-bit byte stream, MSB byte first, on the fast clock and rebuilds 32-bit words. It presents each completed word with a one-cycle valid strobe and a running word count. A partial word, caused by `valid_in` dropping before the fourth byte, is discarded.

---
 rtl/conv_8b_32b.sv | 82 ++++++++
 tb/tb_conv_8b_32b.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_8b_32b.sv
// conv_8b_32b: rebuilds 32-bit words from an MSB-first byte stream on clk_4f.
// A word in progress is dropped if valid_in falls before its fourth byte.
// The optional err_partial strobe is built only when CONV8B32B_ERR_EN is defined.
module conv_8b_32b #(
   parameter int unsigned WCNT_W = 16
) (
   input  logic              clk_4f,
   input  logic              reset_L,
   input  logic [7:0]        data_in,
   input  logic              valid_in,
   output logic [31:0]       data_out,
   output logic              valid_out,
   output logic [WCNT_W-1:0] word_count
`ifdef CONV8B32B_ERR_EN
   ,
   output logic              err_partial
`endif
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ASM_W  = 24;
   localparam int unsigned IDX_W  = 2;

   logic [IDX_W-1:0] idx;
   logic [ASM_W-1:0] asm_reg;

   // Byte index and assembly of the word, plus the output register and the counter
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         idx        <= '0;
         asm_reg    <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         word_count <= '0;
      end else begin
         valid_out <= 1'b0;
         if (valid_in) begin
            case (idx)
               2'd0: begin
                  asm_reg[23:16] <= data_in;
                  idx            <= 2'd1;
               end
               2'd1: begin
                  asm_reg[15:8] <= data_in;
                  idx           <= 2'd2;
               end
               2'd2: begin
                  asm_reg[7:0] <= data_in;
                  idx          <= 2'd3;
               end
               default: begin
                  data_out   <= {asm_reg, data_in};
                  valid_out  <= 1'b1;
                  word_count <= word_count + WCNT_W'(1);
                  idx        <= 2'd0;
               end
            endcase
         end else begin
            // A gap in the stream realigns to byte 0 and discards any partial word
            idx     <= '0;
            asm_reg <= '0;
         end
      end
   end

`ifdef CONV8B32B_ERR_EN
   // One-cycle flag when a gap cuts off a word that was already started
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         err_partial <= 1'b0;
      end else begin
         err_partial <= !valid_in && (idx != '0);
      end
   end
`endif

   // BYTE_W documents the lane width of data_in
   if (BYTE_W != 8) begin : g_bad_width
      $error("conv_8b_32b: byte lane must be 8 bits");
   end

endmodule

// File: tb/tb_conv_8b_32b.sv
// Self-checking bench for conv_8b_32b: vector table, hand-written corner cases,
// and random traffic against a queue-based reference model.
module tb_conv_8b_32b;

   logic        clk_4f = 1'b0;
   logic        reset_L;
   logic [7:0]  data_in;
   logic        valid_in;
   logic [31:0] data_out;
   logic        valid_out;
   logic [15:0] word_count;
   logic [31:0] data_out2;
   logic        valid_out2;
   logic [1:0]  word_count2;
`ifdef CONV8B32B_ERR_EN
   logic        err_partial;
   logic        err_partial2;
`endif

   always #5 clk_4f = ~clk_4f;

   conv_8b_32b #(.WCNT_W(16)) dut (
      .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
      .data_out(data_out), .valid_out(valid_out), .word_count(word_count)
`ifdef CONV8B32B_ERR_EN
      , .err_partial(err_partial)
`endif
   );

   conv_8b_32b #(.WCNT_W(2)) dut2 (
      .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
      .data_out(data_out2), .valid_out(valid_out2), .word_count(word_count2)
`ifdef CONV8B32B_ERR_EN
      , .err_partial(err_partial2)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference model: bytes of the current run, last word, word tally, strobes
   logic [7:0]  m_q[$];
   logic [31:0] m_data  = '0;
   int unsigned m_cnt   = 0;
   bit          m_valid = 1'b0;
   bit          m_err   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("data_out", data_out, m_data);
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("word_count", 32'(word_count), m_cnt % 65536);
      chk("data_out_w2", data_out2, m_data);
      chk("word_count_w2", 32'(word_count2), m_cnt % 4);
`ifdef CONV8B32B_ERR_EN
      chk("err_partial", 32'(err_partial), 32'(m_err));
`endif
   endtask

   task automatic model_step(input bit v, input logic [7:0] d);
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (v) begin
         m_q.push_back(d);
         if (m_q.size() == 4) begin
            m_data  = {m_q[0], m_q[1], m_q[2], m_q[3]};
            m_cnt   = m_cnt + 1;
            m_valid = 1'b1;
            m_q.delete();
         end
      end else begin
         if (m_q.size() != 0) m_err = 1'b1;
         m_q.delete();
      end
   endtask

   // Drive one byte slot, let one rising edge pass, then compare with the model
   task automatic apply(input bit v, input logic [7:0] d);
      @(negedge clk_4f);
      valid_in = v;
      data_in  = d;
      @(posedge clk_4f);
      #1;
      model_step(v, d);
      check_all();
   endtask

   // Assert reset mid-cycle; outputs must clear without waiting for a clock edge
   task automatic do_reset();
      @(negedge clk_4f);
      valid_in = 1'b0;
      reset_L  = 1'b0;
      #1;
      m_q.delete();
      m_data  = '0;
      m_cnt   = 0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      check_all();
      @(negedge clk_4f);
      reset_L = 1'b1;
   endtask

   typedef struct {
      bit          v;
      logic [7:0]  d;
      bit          ev;
      logic [31:0] ed;
      logic [15:0] ec;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [1:0] exp_w2[5];
      int         nwords;

      reset_L  = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'h00;

      // DEADBEEF, then 0x01..0x08 back to back, then one idle cycle
      tbl[0]  = '{1'b1, 8'hDE, 1'b0, 32'h0000_0000, 16'd0};
      tbl[1]  = '{1'b1, 8'hAD, 1'b0, 32'h0000_0000, 16'd0};
      tbl[2]  = '{1'b1, 8'hBE, 1'b0, 32'h0000_0000, 16'd0};
      tbl[3]  = '{1'b1, 8'hEF, 1'b1, 32'hDEAD_BEEF, 16'd1};
      tbl[4]  = '{1'b1, 8'h01, 1'b0, 32'hDEAD_BEEF, 16'd1};
      tbl[5]  = '{1'b1, 8'h02, 1'b0, 32'hDEAD_BEEF, 16'd1};
      tbl[6]  = '{1'b1, 8'h03, 1'b0, 32'hDEAD_BEEF, 16'd1};
      tbl[7]  = '{1'b1, 8'h04, 1'b1, 32'h0102_0304, 16'd2};
      tbl[8]  = '{1'b1, 8'h05, 1'b0, 32'h0102_0304, 16'd2};
      tbl[9]  = '{1'b1, 8'h06, 1'b0, 32'h0102_0304, 16'd2};
      tbl[10] = '{1'b1, 8'h07, 1'b0, 32'h0102_0304, 16'd2};
      tbl[11] = '{1'b1, 8'h08, 1'b1, 32'h0506_0708, 16'd3};
      tbl[12] = '{1'b0, 8'h5A, 1'b0, 32'h0506_0708, 16'd3};

      do_reset();
      for (int i = 0; i < 13; i++) begin
         apply(tbl[i].v, tbl[i].d);
         chk("tbl_data", data_out, tbl[i].ed);
         chk("tbl_valid", 32'(valid_out), 32'(tbl[i].ev));
         chk("tbl_count", 32'(word_count), 32'(tbl[i].ec));
      end

      // Partial word cut by a one-cycle gap, then a full word
      do_reset();
      apply(1'b1, 8'hAA);
      apply(1'b1, 8'hBB);
      apply(1'b0, 8'h00);
`ifdef CONV8B32B_ERR_EN
      chk("partial_err_pulse", 32'(err_partial), 32'd1);
`endif
      apply(1'b1, 8'h11);
      apply(1'b1, 8'h22);
      apply(1'b1, 8'h33);
      apply(1'b1, 8'h44);
      chk("partial_data", data_out, 32'h1122_3344);
      chk("partial_count", 32'(word_count), 32'd1);

      // Reset after three bytes, then a fresh word
      apply(1'b1, 8'h12);
      apply(1'b1, 8'h34);
      apply(1'b1, 8'h56);
      do_reset();
      chk("rst_data_zero", data_out, 32'h0);
      chk("rst_count_zero", 32'(word_count), 32'd0);
      apply(1'b1, 8'hCA);
`ifdef CONV8B32B_ERR_EN
      chk("rst_no_err", 32'(err_partial), 32'd0);
`endif
      apply(1'b1, 8'hFE);
      apply(1'b1, 8'hF0);
      apply(1'b1, 8'h0D);
      chk("rst_next_word", data_out, 32'hCAFE_F00D);
      chk("rst_next_count", 32'(word_count), 32'd1);

      // Idle with toggling data: nothing may move
      for (int i = 0; i < 10; i++) apply(1'b0, 8'(i[0] ? 8'hFF : 8'h00));
      chk("idle_hold_data", data_out, 32'hCAFE_F00D);

      // Narrow counter wraps 1,2,3,0,1 across five words
      do_reset();
      exp_w2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      nwords = 0;
      for (int i = 0; i < 20; i++) begin
         apply(1'b1, 8'($urandom));
         if ((i % 4) == 3) begin
            chk("wrap_w2", 32'(word_count2), 32'(exp_w2[nwords]));
            nwords++;
         end
      end

      // Random traffic with gaps
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 4) != 0, 8'($urandom));
      end
      apply(1'b0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
